// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl
// Multi-cycle signed add/subtract of two W = 4*NIBBLES bit operands, built on an
// external combinational 4-bit adder-subtractor unit. One nibble is processed per
// clock, least significant first, with the carry chained through a register.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only while idle
//   op_sub            0 = a+b, 1 = a-b (latched on accept)
//   op_a, op_b        W-bit two's-complement operands (latched on accept)
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle pulse; result/carry/oflow valid
//   result            W-bit sum or difference (working register during a run)
//   carry             carry out of the MSB nibble (subtract: 1 = no borrow)
//   oflow             signed overflow of the full W-bit operation
//   au_sub/a/b/ci     drive to the 4-bit unit (all zero outside a run)
//   au_z/co/oflow     results back from the 4-bit unit
module addsub_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         oflow,
    output logic         au_sub,
    output logic [3:0]   au_a,
    output logic [3:0]   au_b,
    output logic         au_ci,
    input  logic [3:0]   au_z,
    input  logic         au_co,
    input  logic         au_oflow
);

    // Index width kept at least 1 bit so NIBBLES = 1 still elaborates.
    localparam int            IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          sub_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [IW-1:0] idx_reg;
    logic          chain_reg;     // carry into the nibble currently on the unit
    logic          carry_reg;
    logic          oflow_reg;

    // Operand nibble views so the unit mux is a plain array select.
    logic [3:0] a_nib [NIBBLES];
    logic [3:0] b_nib [NIBBLES];

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        logic [3:0] res_nib_reg;

        assign a_nib[gi] = a_reg[4*gi +: 4];
        assign b_nib[gi] = b_reg[4*gi +: 4];

        // Each result nibble is captured only on the RUN cycle that owns it, so
        // lower nibbles stay visible while the upper ones are still in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_nib_reg <= 4'h0;
            end else if (state_reg == S_RUN && idx_reg == IW'(gi)) begin
                res_nib_reg <= au_z;
            end
        end

        assign result[4*gi +: 4] = res_nib_reg;
    end

    always_comb begin
        state_next = state_reg;
        au_sub     = 1'b0;
        au_a       = 4'h0;
        au_b       = 4'h0;
        au_ci      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                au_sub = sub_reg;
                au_a   = a_nib[idx_reg];
                au_b   = b_nib[idx_reg];
                au_ci  = chain_reg;
                if (idx_reg == LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            sub_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            chain_reg <= 1'b0;
            carry_reg <= 1'b0;
            oflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sub_reg   <= op_sub;
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        idx_reg   <= '0;
                        // Subtract is a + ~b + 1: the +1 enters as nibble 0 carry-in.
                        chain_reg <= op_sub;
                    end
                end
                S_RUN: begin
                    chain_reg <= au_co;
                    if (idx_reg == LAST) begin
                        idx_reg   <= '0;
                        carry_reg <= au_co;
                        oflow_reg <= au_oflow;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (state_reg != S_IDLE);
    assign done  = (state_reg == S_DONE);
    assign carry = carry_reg;
    assign oflow = oflow_reg;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
module tb_addsub_seq_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         oflow;
    logic         au_sub;
    logic [3:0]   au_a;
    logic [3:0]   au_b;
    logic         au_ci;
    logic [3:0]   au_z;
    logic         au_co;
    logic         au_oflow;

    int total = 0;
    int bad   = 0;

    // Snapshot of one transaction, filled by run_op.
    int           lat_s;
    int           busy_s;
    int           done_s;
    logic [W-1:0] res_s;
    logic         car_s;
    logic         ofl_s;
    logic         fc_sub;
    logic [3:0]   fc_a;
    logic [3:0]   fc_b;
    logic         fc_ci;

    addsub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .oflow    (oflow),
        .au_sub   (au_sub),
        .au_a     (au_a),
        .au_b     (au_b),
        .au_ci    (au_ci),
        .au_z     (au_z),
        .au_co    (au_co),
        .au_oflow (au_oflow)
    );

    // Behavioural 4-bit adder-subtractor unit: z = a + (b ^ sub) + ci,
    // oflow = carry into bit 3 XOR carry out of bit 3.
    logic [3:0] bx;
    logic [3:0] lo;
    logic [4:0] sum;
    always_comb begin
        bx       = au_b ^ {4{au_sub}};
        sum      = {1'b0, au_a} + {1'b0, bx} + {4'b0, au_ci};
        lo       = {1'b0, au_a[2:0]} + {1'b0, bx[2:0]} + {3'b0, au_ci};
        au_z     = sum[3:0];
        au_co    = sum[4];
        au_oflow = lo[3] ^ sum[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it until done has come and gone.
    task automatic run_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
        op_sub = sub;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        fc_sub = au_sub;
        fc_a   = au_a;
        fc_b   = au_b;
        fc_ci  = au_ci;
        lat_s  = 0;
        busy_s = 0;
        done_s = 0;
        res_s  = '0;
        car_s  = 1'b0;
        ofl_s  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) busy_s++;
            if (done) begin
                done_s++;
                if (lat_s == 0) begin
                    lat_s = k;
                    res_s = result;
                    car_s = carry;
                    ofl_s = oflow;
                end
            end
            if (lat_s != 0 && !done && !busy) break;
            tick();
        end
        $display("op sub=%0d a=%h b=%h -> result=%h carry=%0d oflow=%0d lat=%0d",
                 sub, a, b, res_s, car_s, ofl_s, lat_s);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        op_a   = '0;
        op_b   = '0;
        #12;
        total++;
        if ({busy, done, carry, oflow, au_sub, au_ci} !== 6'b0 || result !== 16'h0 ||
            au_a !== 4'h0 || au_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b result=%h carry=%b oflow=%b au=%b/%h/%h/%b, want all 0",
                     busy, done, result, carry, oflow, au_sub, au_a, au_b, au_ci);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add_basic();
        run_op(1'b0, 16'h1234, 16'h0FFF);
        total++;
        if (res_s !== 16'h2233 || car_s !== 1'b0 || ofl_s !== 1'b0) begin
            bad++;
            $display("FAIL add_basic: result=%h carry=%b oflow=%b, want 2233 0 0", res_s, car_s, ofl_s);
        end
        total++;
        if (lat_s !== 5) begin
            bad++;
            $display("FAIL add_latency: done at cycle %0d, want 5", lat_s);
        end
        total++;
        if (done_s !== 1) begin
            bad++;
            $display("FAIL done_pulse: done high %0d cycles, want 1", done_s);
        end
        total++;
        if (busy_s !== 5) begin
            bad++;
            $display("FAIL busy_len: busy high %0d cycles, want 5", busy_s);
        end
        total++;
        if (fc_sub !== 1'b0 || fc_a !== 4'h4 || fc_b !== 4'hF || fc_ci !== 1'b0) begin
            bad++;
            $display("FAIL add_nib0: au=%b/%h/%h/%b, want 0/4/f/0", fc_sub, fc_a, fc_b, fc_ci);
        end
    endtask

    task automatic test_sub_basic();
        run_op(1'b1, 16'h0005, 16'h0007);
        total++;
        if (res_s !== 16'hFFFE || car_s !== 1'b0 || ofl_s !== 1'b0) begin
            bad++;
            $display("FAIL sub_basic: result=%h carry=%b oflow=%b, want fffe 0 0", res_s, car_s, ofl_s);
        end
        total++;
        if (fc_sub !== 1'b1 || fc_a !== 4'h5 || fc_b !== 4'h7 || fc_ci !== 1'b1) begin
            bad++;
            $display("FAIL sub_nib0: au=%b/%h/%h/%b, want 1/5/7/1", fc_sub, fc_a, fc_b, fc_ci);
        end
    endtask

    task automatic test_overflow();
        run_op(1'b0, 16'h7FFF, 16'h0001);
        total++;
        if (res_s !== 16'h8000 || car_s !== 1'b0 || ofl_s !== 1'b1) begin
            bad++;
            $display("FAIL add_oflow: result=%h carry=%b oflow=%b, want 8000 0 1", res_s, car_s, ofl_s);
        end
        run_op(1'b0, 16'hFFFF, 16'h0001);
        total++;
        if (res_s !== 16'h0000 || car_s !== 1'b1 || ofl_s !== 1'b0) begin
            bad++;
            $display("FAIL add_carry: result=%h carry=%b oflow=%b, want 0000 1 0", res_s, car_s, ofl_s);
        end
        run_op(1'b1, 16'h8000, 16'h0001);
        total++;
        if (res_s !== 16'h7FFF || car_s !== 1'b1 || ofl_s !== 1'b1) begin
            bad++;
            $display("FAIL sub_oflow: result=%h carry=%b oflow=%b, want 7fff 1 1", res_s, car_s, ofl_s);
        end
    endtask

    task automatic test_start_while_busy();
        int           lat;
        int           idle_at;
        int           again_at;
        logic [W-1:0] res;
        op_sub = 1'b0;
        op_a   = 16'h1111;
        op_b   = 16'h2222;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = 0;
        res    = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k >= 2 && k <= 4) begin
                start  = 1'b1;
                op_sub = 1'b1;
                op_a   = 16'hAAAA;
                op_b   = 16'h5555;
            end else begin
                start  = 1'b0;
            end
            if (done && lat == 0) begin
                lat = k;
                res = result;
            end
            if (lat != 0 && !busy) break;
            tick();
        end
        $display("op sub=0 a=1111 b=2222 with stray starts -> result=%h lat=%0d", res, lat);
        total++;
        if (res !== 16'h3333 || lat !== 5) begin
            bad++;
            $display("FAIL ignore_start: result=%h lat=%0d, want 3333 5", res, lat);
        end

        // Hold start high across a whole operation.
        op_sub = 1'b0;
        op_a   = 16'h0001;
        op_b   = 16'h0002;
        start  = 1'b1;
        tick();
        idle_at  = 0;
        again_at = 0;
        for (int j = 1; j <= 20; j++) begin
            if (!busy && idle_at == 0) idle_at = j;
            if (idle_at != 0 && busy) begin
                again_at = j;
                break;
            end
            tick();
        end
        start = 1'b0;
        $display("held start: idle at cycle %0d, re-accepted (busy) at cycle %0d", idle_at, again_at);
        total++;
        if (again_at - 1 !== N + 2) begin
            bad++;
            $display("FAIL issue_interval: second accept %0d edges after first, want %0d", again_at - 1, N + 2);
        end
        res = '0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            tick();
        end
        total++;
        if (lat == 0 || res !== 16'h0003) begin
            bad++;
            $display("FAIL held_result: result=%h seen=%0d, want 0003 seen", res, lat);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        op_sub = 1'b1;
        op_a   = 16'h1234;
        op_b   = 16'h0001;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();            // second RUN cycle; nibble 0 already written
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, carry, oflow, au_sub, au_ci} !== 6'b0 || result !== 16'h0 ||
            au_a !== 4'h0 || au_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b done=%b result=%h carry=%b oflow=%b au=%b/%h/%h/%b, want all 0",
                     busy, done, result, carry, oflow, au_sub, au_a, au_b, au_ci);
        end
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done) done_seen++;
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) done_seen++;
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL abandoned_op: busy/done seen %0d cycles after reset, want 0", done_seen);
        end
        run_op(1'b1, 16'h0100, 16'h0001);
        total++;
        if (res_s !== 16'h00FF || car_s !== 1'b1 || ofl_s !== 1'b0 || lat_s !== 5) begin
            bad++;
            $display("FAIL post_reset_sub: result=%h carry=%b oflow=%b lat=%0d, want 00ff 1 0 5",
                     res_s, car_s, ofl_s, lat_s);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_sub_basic();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/addsub_seq_ctrl.md
Name: addsub_seq_ctrl

Overview:
Multi-cycle controller that performs a 4*NIBBLES-bit signed add or subtract on the team's 4-bit adder-subtractor unit. It processes one nibble per clock, least significant first, and chains the carry through an internal register. The 4-bit unit stays external and combinational; this block drives its sub/a/b/ci inputs and samples its z/co/oflow outputs. It has a start/busy/done handshake toward the requester.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; word width W = 4*NIBBLES; legal values >= 1.

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op_sub  in  1  0 = a+b, 1 = a-b; captured on accept
op_a  in  W  signed 2's-complement operand a; captured on accept
op_b  in  W  signed 2's-complement operand b; captured on accept
busy  out  1  high from the cycle after accept through the DONE cycle inclusive
done  out  1  single-cycle pulse; result/carry/oflow valid
result  out  W  signed sum or difference
carry  out  1  carry out of the MSB nibble; for subtract, 1 = no borrow
oflow  out  1  signed overflow of the full W-bit operation
au_sub  out  1  to unit sub
au_a  out  4  to unit a
au_b  out  4  to unit b; raw nibble, the unit applies the XOR with sub itself
au_ci  out  1  to unit ci
au_z  in  4  from unit z
au_co  in  1  from unit co
au_oflow  in  1  from unit oflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. On reset assertion:
  - state = IDLE
  - busy = 0, done = 0
  - result = 0, carry = 0, oflow = 0
  - nibble index = 0
  - all au_* outputs = 0
  - Takes effect immediately, including mid-RUN. The operation is abandoned and no done is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - au_* outputs driven 0.
  - On start=1 at a clock edge: latch op_sub/op_a/op_b, set idx=0, set carry_reg=op_sub, go to RUN.
  - result/carry/oflow keep their previous values until overwritten.
- RUN (exactly NIBBLES cycles):
  - Combinational drive: au_sub = latched sub; au_a = a[4*idx+3:4*idx]; au_b = b[4*idx+3:4*idx]; au_ci = carry_reg.
  - At each edge: result[4*idx+3:4*idx] <= au_z; carry_reg <= au_co; idx <= idx+1.
  - When idx == NIBBLES-1, also: carry <= au_co; oflow <= au_oflow; go to DONE.
  - Subtract correctness depends on au_ci = 1 for nibble 0 (a + ~b + 1).
- DONE (one cycle): done = 1, busy = 1; go to IDLE at the next edge. done is never high for 2 consecutive cycles.
- Latency: accept at edge 0 -> done high in the cycle following edge NIBBLES (NIBBLES+1 cycles from accept). Back-to-back: start may be held high, and the next operation is accepted on the edge that leaves DONE? No: acceptance occurs only in IDLE, so the minimum issue interval is NIBBLES+2 cycles.
- start while busy: ignored. No queueing, no error flag.
- Operand changes after accept have no effect; operands are latched.
- result is a working register. Partial nibbles are visible during RUN, and requesters sample only when done=1.
- Arithmetic: result = (op_a ± op_b) mod 2^W. carry = bit W of op_a + (op_sub ? ~op_b + 1 : op_b). oflow = carry into MSB XOR carry out of MSB, as reported by the unit on the final nibble.
- NIBBLES = 1: RUN lasts one cycle, and behaviour equals a single registered pass through the unit.

Test Plan:
(Bench instantiates addsub_seq_ctrl, NIBBLES=4, wired to the team's 4-bit adder-subtractor unit.)
1. add 0x1234 + 0x0FFF -> result 0x2233, carry 0, oflow 0. done pulses exactly once, 5 cycles after the accept edge; busy high for 5 cycles.
2. sub 0x0005 - 0x0007 -> result 0xFFFE, carry 0, oflow 0. Nibble 0 has au_ci = 1.
3. add 0x7FFF + 0x0001 -> result 0x8000, oflow 1, carry 0. Also add 0xFFFF + 0x0001 -> result 0x0000, carry 1, oflow 0.
4. sub 0x8000 - 0x0001 -> result 0x7FFF, carry 1, oflow 1.
5. Pulse start with new operands in cycles 2-4 of a running add -> ignored; original result delivered. Holding start high gives a second accept NIBBLES+2 cycles after the first.
6. Deassert rst_n in the 2nd RUN cycle -> busy/done/result/carry/oflow/au_* = 0 immediately and no done. After release, sub 0x0100 - 0x0001 -> result 0x00FF, carry 1, oflow 0.
